shift_reg_seq: RTL

- Parametrised multi-mode shift/rotate register; generalises the 8-bit fixed-mode shifter to WIDTH bits, variable shift amount, and configurable positions-per-cycle.
- Performs multi-position operations over several cycles behind a start/busy/done handshake, with serial in/out for chaining.
- Sits in the datapath shifter group; drives data_out directly to downstream logic.

---
 rtl/shift_reg_pkg.sv | 41 ++++
 rtl/shift_reg_step.sv | 65 ++++++
 rtl/shift_reg_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the multi-mode shift/rotate register.
// No logic of its own; consumed by shift_reg_seq and shift_reg_step.
// Backpressure: n/a.
package shift_reg_pkg;

    localparam int OP_W = 3;

    // Operation codes as carried on the op port.
    typedef enum logic [OP_W-1:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SLL  = 3'b010,
        OP_SRL  = 3'b011,
        OP_SRA  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_SER  = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Number of positions actually moved for a requested amount.
    // Linear shifts saturate at the register width (everything falls out),
    // rotates fold one multiple of the width away, serial fill is literal.
    function automatic int unsigned eff_amount(input op_e op,
                                               input int unsigned amt,
                                               input int unsigned width);
        int unsigned r;
        r = amt;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: if (amt > width) r = width;
            OP_ROL, OP_ROR:         if (amt >= width) r = amt - width;
            default:                r = amt;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_reg_step.sv
// Combinational single step: moves value by k positions according to op.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is registered.
module shift_reg_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] k,
    input  logic             serial_in,
    output logic [WIDTH-1:0] next_value,
    output logic             out_bit
);

    localparam logic [AMT_W-1:0] W_A = AMT_W'(WIDTH);

    logic left_bit;
    logic right_bit;

    // Last bit to leave: bit WIDTH-k for left moves, bit k-1 for right moves.
    always_comb begin
        left_bit  = |(value & (WIDTH'(1) << (W_A - k)));
        right_bit = |(value & (WIDTH'(1) << (k - 1'b1)));
    end

    // Apply the k-position move selected by op.
    always_comb begin
        next_value = value;
        out_bit    = 1'b0;
        case (op_e'(op))
            OP_SLL: begin
                next_value = value << k;
                out_bit    = left_bit;
            end
            OP_SRL: begin
                next_value = value >> k;
                out_bit    = right_bit;
            end
            OP_SRA: begin
                next_value = $unsigned($signed(value) >>> k);
                out_bit    = right_bit;
            end
            OP_ROL: begin
                next_value = (value << k) | (value >> (W_A - k));
                out_bit    = left_bit;
            end
            OP_ROR: begin
                next_value = (value >> k) | (value << (W_A - k));
                out_bit    = right_bit;
            end
            OP_SER: begin
                next_value = {value[WIDTH-2:0], serial_in};
                out_bit    = value[WIDTH-1];
            end
            default: begin
                next_value = value;
                out_bit    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_reg_seq.sv
// Multi-cycle shift/rotate register with start/busy/done handshake and serial chaining.
// Latency: 1 edge for HOLD/LOAD/zero amount, ceil(amt/STEP)+1 for shifts, amt+1 for SER.
// Backpressure: enable=0 freezes all state; start is ignored while busy.
module shift_reg_seq
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

    state_e           state, state_nxt;
    op_e              op_q, op_nxt;
    logic [AMT_W-1:0] count, count_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic             sout_nxt;
    logic             done_nxt;
    logic [AMT_W-1:0] eff_amt;
    logic [AMT_W-1:0] k;
    logic [WIDTH-1:0] step_value;
    logic             step_out;

    assign busy = (state == ST_RUN);

    // Positions to move this RUN cycle: serial fill is always one bit at a time.
    always_comb begin
        eff_amt = AMT_W'(eff_amount(op_e'(op), 32'(amount), 32'(WIDTH)));
        if (op_q == OP_SER) begin
            k = AMT_W'(1);
        end else begin
            k = (count < STEP_A) ? count : STEP_A;
        end
    end

    shift_reg_step #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_step (
        .value      (data_out),
        .op         (op_q),
        .k          (k),
        .serial_in  (serial_in),
        .next_value (step_value),
        .out_bit    (step_out)
    );

    // Next-state, count and datapath selection; done is a one-cycle pulse by default.
    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        count_nxt = count;
        data_nxt  = data_out;
        sout_nxt  = serial_out;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                // abort in the same cycle swallows the request
                if (start && !abort) begin
                    case (op_e'(op))
                        OP_HOLD: done_nxt = 1'b1;
                        OP_LOAD: begin
                            data_nxt = data_in;
                            done_nxt = 1'b1;
                        end
                        default: begin
                            if (eff_amt == '0) begin
                                done_nxt = 1'b1;
                            end else begin
                                op_nxt    = op_e'(op);
                                count_nxt = eff_amt;
                                state_nxt = ST_RUN;
                            end
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // partial result stays visible, no completion pulse
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                end else begin
                    data_nxt  = step_value;
                    sout_nxt  = step_out;
                    count_nxt = count - k;
                    if (count == k) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and datapath registers: reset wins, enable=0 holds everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            op_q       <= OP_HOLD;
            count      <= '0;
            data_out   <= '0;
            serial_out <= 1'b0;
            done       <= 1'b0;
        end else if (enable) begin
            state      <= state_nxt;
            op_q       <= op_nxt;
            count      <= count_nxt;
            data_out   <= data_nxt;
            serial_out <= sout_nxt;
            done       <= done_nxt;
        end
    end

endmodule
